colour_mask_filter: RTL
=======================

COLOUR_MASK_FILTER -- requirements
Module: colour_mask_filter

Interface
REQ-001 SHALL have parameter MIN_PIXELS, default 64: latched frame pixel count at or above which oDetect asserts.
REQ-002 SHALL have parameter MARGIN_W, default 8: width of iMargin.
REQ-003 SHALL have port iCLK, input, 1: pixel clock (MIPI pixel clock domain); single clock for all logic.
REQ-004 SHALL have port iRST_N, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port iValid, input, 1: qualifies iRed/iGreen/iBlue/iX/iY this cycle (driven by VGA read request).
REQ-006 SHALL have ports iRed, iGreen, iBlue, input, 8 each: camera RGB pixel.
REQ-007 SHALL have ports iX, input, 10, and iY, input, 9: active-area pixel coordinates, 0..639 and 0..479.
REQ-008 SHALL have port iFrameStart, input, 1: single-cycle pulse at start of each frame.
REQ-009 SHALL have port iMode, input, 2: 00 passthrough, 01 red, 10 green, 11 blue target colour.
REQ-010 SHALL have port iMargin, input, MARGIN_W: dominance margin.
REQ-011 SHALL have ports oRed, oGreen, oBlue, output, 8 each: filtered pixel to VGA controller.
REQ-012 SHALL have port oValid, output, 1: qualifies oRed/oGreen/oBlue.
REQ-013 SHALL have port oCount, output, 19: matched pixels in last completed frame.
REQ-014 SHALL have ports oMinX/oMaxX, output, 10, and oMinY/oMaxY, output, 9: bounding box of matched pixels in last completed frame.
REQ-015 SHALL have port oFrameDone, output, 1: one-cycle pulse when statistics update.
REQ-016 SHALL have port oDetect, output, 1: oCount >= MIN_PIXELS.

Function
REQ-017 SHALL be a 2-stage pipeline; oValid equals iValid delayed exactly 2 cycles; pixel data on oRed/oGreen/oBlue aligned with oValid.
REQ-018 Stage 1 SHALL register the inputs and compute diff = target channel - max(other two channels) as 9-bit signed.
REQ-019 Stage 2 SHALL assert match when iMode != 00, stage-1 valid = 1, and diff > zero-extended iMargin (strictly greater).
REQ-020 On match, output SHALL equal the stage-1 RGB unchanged; otherwise, in modes 01-11, each output channel SHALL equal grey = (R + 2G + B) >> 2, computed in 10 bits and truncated to 8.
REQ-021 In mode 00, output SHALL equal the input RGB unchanged, and match SHALL never assert.
REQ-022 iMode and iMargin SHALL be sampled in stage 1 alongside the pixel; a mid-frame change affects only pixels entering after the change.
REQ-023 Accumulator on each stage-2 match: count += 1, saturating at 524287; minX = min(minX, x), maxX = max(maxX, x), same for Y, using the pipelined coordinates.
REQ-024 On iFrameStart: latch accumulators into oCount/oMin*/oMax*, pulse oFrameDone on the next cycle, and clear accumulators (count 0, min = all-ones, max = 0).
REQ-025 If accumulated count is 0 at latch, oMinX/oMaxX/oMinY/oMaxY SHALL latch as 0.
REQ-026 If a match and iFrameStart occur in the same cycle, the matching pixel SHALL be excluded from the latched frame and SHALL seed the new frame (count 1, min = max = its coordinates).
REQ-027 oDetect SHALL be registered and update in the same cycle as oCount.
REQ-028 Pixels with iValid = 0 SHALL not advance statistics; pipeline registers still shift each cycle (no stall).

Reset
REQ-029 While iRST_N = 0: all outputs 0, pipeline valids 0, accumulators cleared per REQ-024.
REQ-030 Reset deassertion mid-frame: statistics from the partial frame SHALL be reported at the next iFrameStart; the first latched frame may be partial.

Verification
REQ-031 Mode 01, margin 16, pixel (200,40,30) valid at cycle 0 -> cycle 2 oValid = 1, output (200,40,30); pixel (100,90,80) -> output (90,90,90).
REQ-032 Mode 00, any pixel stream -> output identical to input with 2-cycle delay; after iFrameStart, oCount = 0, all bounds 0, oDetect = 0.
REQ-033 Mode 10, margin 0, 100 matching green pixels spanning x 10..50, y 5..20, then iFrameStart -> oFrameDone pulses once; oCount = 100, oMinX = 10, oMaxX = 50, oMinY = 5, oMaxY = 20, oDetect = 1.
REQ-034 Diff exactly equal to margin (mode 11, B = 120, R = G = 100, margin 20) -> no match, grey output 105.
REQ-035 Match reaching stage 2 in the same cycle as iFrameStart -> excluded from latched count; next frame's latched count includes it.
REQ-036 iRST_N asserted mid-frame with 30 matches accumulated -> outputs 0 immediately; next latched oCount counts only post-reset matches.

Source files
------------

// File: rtl/colour_mask_filter.sv
// Two-stage colour dominance filter for a camera-to-VGA pixel stream.
// Matching pixels pass through in colour, others become grey, and per-frame match statistics are reported.
module colour_mask_filter #(
   parameter int MIN_PIXELS = 64,
   parameter int MARGIN_W   = 8
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                iValid,
   input  logic [7:0]          iRed,
   input  logic [7:0]          iGreen,
   input  logic [7:0]          iBlue,
   input  logic [9:0]          iX,
   input  logic [8:0]          iY,
   input  logic                iFrameStart,
   input  logic [1:0]          iMode,
   input  logic [MARGIN_W-1:0] iMargin,
   output logic [7:0]          oRed,
   output logic [7:0]          oGreen,
   output logic [7:0]          oBlue,
   output logic                oValid,
   output logic [18:0]         oCount,
   output logic [9:0]          oMinX,
   output logic [9:0]          oMaxX,
   output logic [8:0]          oMinY,
   output logic [8:0]          oMaxY,
   output logic                oFrameDone,
   output logic                oDetect
);

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_RED   = 2'b01,
      MODE_GREEN = 2'b10,
      MODE_BLUE  = 2'b11
   } mode_e;

   localparam int          CMP_W        = MARGIN_W + 10;
   localparam logic [18:0] COUNT_MAX    = '1;
   localparam logic [18:0] MIN_PIXELS_C = 19'(MIN_PIXELS);

   // Stage 1: registered pixel plus the mode/margin that travel with it
   logic                s1_valid_q,  s1_valid_d;
   logic [7:0]          s1_red_q,    s1_red_d;
   logic [7:0]          s1_green_q,  s1_green_d;
   logic [7:0]          s1_blue_q,   s1_blue_d;
   logic [9:0]          s1_x_q,      s1_x_d;
   logic [8:0]          s1_y_q,      s1_y_d;
   mode_e               s1_mode_q,   s1_mode_d;
   logic [MARGIN_W-1:0] s1_margin_q, s1_margin_d;

   // Stage 2: filtered output pixel
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_red_q,   out_red_d;
   logic [7:0] out_green_q, out_green_d;
   logic [7:0] out_blue_q,  out_blue_d;

   // Running statistics for the frame in progress
   logic [18:0] acc_count_q, acc_count_d;
   logic [9:0]  acc_min_x_q, acc_min_x_d;
   logic [9:0]  acc_max_x_q, acc_max_x_d;
   logic [8:0]  acc_min_y_q, acc_min_y_d;
   logic [8:0]  acc_max_y_q, acc_max_y_d;

   // Statistics of the last completed frame
   logic [18:0] count_q,      count_d;
   logic [9:0]  min_x_q,      min_x_d;
   logic [9:0]  max_x_q,      max_x_d;
   logic [8:0]  min_y_q,      min_y_d;
   logic [8:0]  max_y_q,      max_y_d;
   logic        frame_done_q, frame_done_d;
   logic        detect_q,     detect_d;

   logic [7:0]              target, rival;
   logic signed [8:0]       diff;
   logic signed [CMP_W-1:0] diff_ext, margin_ext;
   logic                    match;
   logic [9:0]              grey_sum;
   logic [7:0]              grey;

   logic [18:0] base_count;
   logic [9:0]  base_min_x, base_max_x;
   logic [8:0]  base_min_y, base_max_y;

   always_comb begin
      s1_valid_d  = iValid;
      s1_red_d    = iRed;
      s1_green_d  = iGreen;
      s1_blue_d   = iBlue;
      s1_x_d      = iX;
      s1_y_d      = iY;
      s1_mode_d   = mode_e'(iMode);
      s1_margin_d = iMargin;
   end

   // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      target = s1_red_q;
      rival  = (s1_green_q >= s1_blue_q) ? s1_green_q : s1_blue_q;
      case (s1_mode_q)
         MODE_GREEN: begin
            target = s1_green_q;
            rival  = (s1_red_q >= s1_blue_q) ? s1_red_q : s1_blue_q;
         end
         MODE_BLUE: begin
            target = s1_blue_q;
            rival  = (s1_red_q >= s1_green_q) ? s1_red_q : s1_green_q;
         end
         default: ;
      endcase
      diff       = $signed({1'b0, target}) - $signed({1'b0, rival});
      diff_ext   = {{(CMP_W-9){diff[8]}}, diff};
      margin_ext = {{(CMP_W-MARGIN_W){1'b0}}, s1_margin_q};
      match      = (s1_mode_q != MODE_PASS) && s1_valid_q && (diff_ext > margin_ext);

      grey_sum = {2'b00, s1_red_q} + {1'b0, s1_green_q, 1'b0} + {2'b00, s1_blue_q};
      grey     = grey_sum[9:2];

      out_valid_d = s1_valid_q;
      out_red_d   = grey;
      out_green_d = grey;
      out_blue_d  = grey;
      if ((s1_mode_q == MODE_PASS) || match) begin
         out_red_d   = s1_red_q;
         out_green_d = s1_green_q;
         out_blue_d  = s1_blue_q;
      end
   end

   // A frame start restarts from the cleared state, so a coincident match seeds the new frame.
   always_comb begin
      base_count = acc_count_q;
      base_min_x = acc_min_x_q;
      base_max_x = acc_max_x_q;
      base_min_y = acc_min_y_q;
      base_max_y = acc_max_y_q;
      if (iFrameStart) begin
         base_count = '0;
         base_min_x = '1;
         base_max_x = '0;
         base_min_y = '1;
         base_max_y = '0;
      end

      acc_count_d = base_count;
      acc_min_x_d = base_min_x;
      acc_max_x_d = base_max_x;
      acc_min_y_d = base_min_y;
      acc_max_y_d = base_max_y;
      if (match) begin
         acc_count_d = (base_count == COUNT_MAX) ? base_count : base_count + 19'd1;
         acc_min_x_d = (s1_x_q < base_min_x) ? s1_x_q : base_min_x;
         acc_max_x_d = (s1_x_q > base_max_x) ? s1_x_q : base_max_x;
         acc_min_y_d = (s1_y_q < base_min_y) ? s1_y_q : base_min_y;
         acc_max_y_d = (s1_y_q > base_max_y) ? s1_y_q : base_max_y;
      end

      count_d      = count_q;
      min_x_d      = min_x_q;
      max_x_d      = max_x_q;
      min_y_d      = min_y_q;
      max_y_d      = max_y_q;
      detect_d     = detect_q;
      frame_done_d = 1'b0;
      if (iFrameStart) begin
         count_d      = acc_count_q;
         detect_d     = (acc_count_q >= MIN_PIXELS_C);
         frame_done_d = 1'b1;
         if (acc_count_q == '0) begin
            min_x_d = '0;
            max_x_d = '0;
            min_y_d = '0;
            max_y_d = '0;
         end else begin
            min_x_d = acc_min_x_q;
            max_x_d = acc_max_x_q;
            min_y_d = acc_min_y_q;
            max_y_d = acc_max_y_q;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         s1_valid_q   <= 1'b0;
         s1_red_q     <= '0;
         s1_green_q   <= '0;
         s1_blue_q    <= '0;
         s1_x_q       <= '0;
         s1_y_q       <= '0;
         s1_mode_q    <= MODE_PASS;
         s1_margin_q  <= '0;
         out_valid_q  <= 1'b0;
         out_red_q    <= '0;
         out_green_q  <= '0;
         out_blue_q   <= '0;
         acc_count_q  <= '0;
         acc_min_x_q  <= '1;
         acc_max_x_q  <= '0;
         acc_min_y_q  <= '1;
         acc_max_y_q  <= '0;
         count_q      <= '0;
         min_x_q      <= '0;
         max_x_q      <= '0;
         min_y_q      <= '0;
         max_y_q      <= '0;
         frame_done_q <= 1'b0;
         detect_q     <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_red_q     <= s1_red_d;
         s1_green_q   <= s1_green_d;
         s1_blue_q    <= s1_blue_d;
         s1_x_q       <= s1_x_d;
         s1_y_q       <= s1_y_d;
         s1_mode_q    <= s1_mode_d;
         s1_margin_q  <= s1_margin_d;
         out_valid_q  <= out_valid_d;
         out_red_q    <= out_red_d;
         out_green_q  <= out_green_d;
         out_blue_q   <= out_blue_d;
         acc_count_q  <= acc_count_d;
         acc_min_x_q  <= acc_min_x_d;
         acc_max_x_q  <= acc_max_x_d;
         acc_min_y_q  <= acc_min_y_d;
         acc_max_y_q  <= acc_max_y_d;
         count_q      <= count_d;
         min_x_q      <= min_x_d;
         max_x_q      <= max_x_d;
         min_y_q      <= min_y_d;
         max_y_q      <= max_y_d;
         frame_done_q <= frame_done_d;
         detect_q     <= detect_d;
      end
   end

   assign oValid     = out_valid_q;
   assign oRed       = out_red_q;
   assign oGreen     = out_green_q;
   assign oBlue      = out_blue_q;
   assign oCount     = count_q;
   assign oMinX      = min_x_q;
   assign oMaxX      = max_x_q;
   assign oMinY      = min_y_q;
   assign oMaxY      = max_y_q;
   assign oFrameDone = frame_done_q;
   assign oDetect    = detect_q;

endmodule
